// File: rtl/timesync_sequencer.sv
// Phase controller for the OFDM time-synchronizer: capture, P/R/M engines, peak search and
// cyclic-prefix removal, with shared input-buffer arbitration and per-stage timeouts.
module timesync_sequencer #(
  parameter int unsigned CAP_LEN     = 2240,
  parameter int unsigned FRAME_SPAN  = 1120,
  parameter int unsigned TIMEOUT_CYC = 262143,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned TO_W        = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_done,
  input  logic             wren,
  output logic             wr_accept,
  output logic [CNT_W-1:0] cap_count,
  output logic             corr_start,
  output logic             energy_start,
  output logic             metric_start,
  output logic             peak_start,
  output logic             cprem_start,
  input  logic             corr_done,
  input  logic             energy_done,
  input  logic             metric_done,
  input  logic             peak_done,
  input  logic             cprem_done,
  input  logic [CNT_W-1:0] peak_idx,
  output logic [CNT_W-1:0] frame_idx,
  output logic [2:0]       buf_grant,
  output logic             out_buff_full,
  output logic             busy,
  output logic             err,
  output logic [2:0]       err_code
);

  typedef enum logic [2:0] {
    StCapture, StCorr, StEnergy, StMetric, StPeak, StCprem, StReady, StError
  } state_e;

  localparam logic [CNT_W-1:0] CapLast = CNT_W'(CAP_LEN - 1);
  localparam logic [CNT_W-1:0] PeakMax = CNT_W'(CAP_LEN - FRAME_SPAN);
  localparam logic [TO_W-1:0]  ToLast  = TO_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cap_count_q, cap_count_d;
  logic [CNT_W-1:0] frame_idx_q, frame_idx_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             err_q, err_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [4:0]       start_q, start_d;
  logic [2:0]       buf_grant_q, buf_grant_d;
  logic             wr_accept_q, wr_accept_d;
  logic             obf_q, obf_d;
  logic             busy_q, busy_d;

  logic             stage_done;
  logic [2:0]       stage_code;
  logic             done_ok;
  logic             to_hit;

  // Next-state and status decisions.
  always_comb begin
    state_d     = state_q;
    cap_count_d = cap_count_q;
    frame_idx_d = frame_idx_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    stage_done  = 1'b0;
    stage_code  = 3'd0;

    unique case (state_q)
      StCorr:   begin stage_done = corr_done;   stage_code = 3'd1; end
      StEnergy: begin stage_done = energy_done; stage_code = 3'd2; end
      StMetric: begin stage_done = metric_done; stage_code = 3'd3; end
      StPeak:   begin stage_done = peak_done;   stage_code = 3'd4; end
      StCprem:  begin stage_done = cprem_done;  stage_code = 3'd5; end
      default:  ;
    endcase

    // A done arriving while the start pulse is still out belongs to a previous run.
    done_ok = stage_done && !(|start_q);
    to_hit  = (to_cnt_q == ToLast);

    if (tx_done) begin
      state_d     = StCapture;
      cap_count_d = '0;
      frame_idx_d = '0;
      err_d       = 1'b0;
      err_code_d  = 3'd0;
    end else begin
      unique case (state_q)
        StCapture: begin
          if (wren) begin
            cap_count_d = cap_count_q + CNT_W'(1);
            if (cap_count_q == CapLast) state_d = StCorr;
          end
        end
        StCorr, StEnergy, StMetric, StPeak, StCprem: begin
          if (done_ok) begin
            unique case (state_q)
              StCorr:   state_d = StEnergy;
              StEnergy: state_d = StMetric;
              StMetric: state_d = StPeak;
              StPeak: begin
                frame_idx_d = peak_idx;
                if (peak_idx > PeakMax) begin
                  state_d    = StError;
                  err_d      = 1'b1;
                  err_code_d = 3'd6;
                end else begin
                  state_d = StCprem;
                end
              end
              StCprem:  state_d = StReady;
              default:  ;
            endcase
          end else if (to_hit) begin
            state_d    = StError;
            err_d      = 1'b1;
            err_code_d = stage_code;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    start_d     = '0;
    buf_grant_d = 3'd0;
    busy_d      = 1'b0;
    unique case (state_d)
      StCapture: buf_grant_d = 3'd1;
      StCorr:    begin buf_grant_d = 3'd2; busy_d = 1'b1; start_d[0] = 1'b1; end
      StEnergy:  begin buf_grant_d = 3'd3; busy_d = 1'b1; start_d[1] = 1'b1; end
      StMetric:  begin busy_d = 1'b1; start_d[2] = 1'b1; end
      StPeak:    begin busy_d = 1'b1; start_d[3] = 1'b1; end
      StCprem:   begin buf_grant_d = 3'd4; busy_d = 1'b1; start_d[4] = 1'b1; end
      default:   ;
    endcase
    if (state_d == state_q) start_d = '0;
    wr_accept_d = (state_d == StCapture);
    obf_d       = (state_d == StReady);
    to_cnt_d    = (busy_d && state_d == state_q) ? to_cnt_q + TO_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StCapture;
      cap_count_q <= '0;
      frame_idx_q <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
      start_q     <= '0;
      buf_grant_q <= 3'd1;
      wr_accept_q <= 1'b1;
      obf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_count_q <= cap_count_d;
      frame_idx_q <= frame_idx_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      start_q     <= start_d;
      buf_grant_q <= buf_grant_d;
      wr_accept_q <= wr_accept_d;
      obf_q       <= obf_d;
      busy_q      <= busy_d;
    end
  end

  assign wr_accept     = wr_accept_q;
  assign cap_count     = cap_count_q;
  assign corr_start    = start_q[0];
  assign energy_start  = start_q[1];
  assign metric_start  = start_q[2];
  assign peak_start    = start_q[3];
  assign cprem_start   = start_q[4];
  assign frame_idx     = frame_idx_q;
  assign buf_grant     = buf_grant_q;
  assign out_buff_full = obf_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_timesync_sequencer.sv
// Randomized bench for timesync_sequencer; expectations come from a stage-level model of the
// capture / engine / timeout / range rules.
module tb_timesync_sequencer;

  localparam int CapLen     = 2240;
  localparam int FrameSpan  = 1120;
  localparam int TimeoutCyc = 100;
  localparam int CntW       = 12;
  localparam int ToW        = 18;
  localparam int PeakMax    = CapLen - FrameSpan;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            tx_done = 1'b0;
  logic            wren = 1'b0;
  logic [4:0]      done_vec = '0;
  logic [CntW-1:0] peak_idx = '0;
  logic            wr_accept, out_buff_full, busy, err;
  logic [CntW-1:0] cap_count, frame_idx;
  logic [2:0]      buf_grant, err_code;
  logic            corr_start, energy_start, metric_start, peak_start, cprem_start;
  logic [4:0]      starts;

  int checks = 0;
  int errors = 0;
  int m_frame = 0;

  assign starts = {cprem_start, peak_start, metric_start, energy_start, corr_start};

  timesync_sequencer #(
    .CAP_LEN    (CapLen),
    .FRAME_SPAN (FrameSpan),
    .TIMEOUT_CYC(TimeoutCyc),
    .CNT_W      (CntW),
    .TO_W       (ToW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_done      (tx_done),
    .wren         (wren),
    .wr_accept    (wr_accept),
    .cap_count    (cap_count),
    .corr_start   (corr_start),
    .energy_start (energy_start),
    .metric_start (metric_start),
    .peak_start   (peak_start),
    .cprem_start  (cprem_start),
    .corr_done    (done_vec[0]),
    .energy_done  (done_vec[1]),
    .metric_done  (done_vec[2]),
    .peak_done    (done_vec[3]),
    .cprem_done   (done_vec[4]),
    .peak_idx     (peak_idx),
    .frame_idx    (frame_idx),
    .buf_grant    (buf_grant),
    .out_buff_full(out_buff_full),
    .busy         (busy),
    .err          (err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed status word: {wr_accept, cap_count, buf_grant, starts, frame_idx, obf, busy, err, code}
  function automatic logic [38:0] snap();
    return {wr_accept, cap_count, buf_grant, starts, frame_idx, out_buff_full, busy, err, err_code};
  endfunction

  function automatic logic [38:0] mk(input bit wa, input int cc, input int g, input logic [4:0] st,
                                     input int fr, input bit obf, input bit bz, input bit er,
                                     input int code);
    logic [CntW-1:0] cc_v, fr_v;
    logic [2:0]      g_v, code_v;
    cc_v   = CntW'(cc);
    fr_v   = CntW'(fr);
    g_v    = 3'(g);
    code_v = 3'(code);
    return {wa, cc_v, g_v, st, fr_v, obf, bz, er, code_v};
  endfunction

  // Buffer owner for stage k (0 corr .. 4 cprem).
  function automatic int grant_of(input int k);
    case (k)
      0:       return 2;
      1:       return 3;
      4:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int rand_delay();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(1, TimeoutCyc + 3));
    return int'($urandom_range(2, 30));
  endfunction

  // Feeds n accepted samples with random gaps; starts from an empty CAPTURE state.
  task automatic capture(input int n);
    int got_n;
    int cyc;
    logic [38:0] e;
    got_n = 0;
    cyc   = 0;
    while (got_n < n && cyc < 8 * CapLen) begin
      wren = ($urandom_range(0, 7) != 0);
      tick();
      cyc++;
      if (wren) got_n++;
      if (got_n < CapLen) e = mk(1, got_n, 1, 5'b0, 0, 0, 0, 0, 0);
      else e = mk(0, CapLen, 2, 5'b00001, 0, 0, 1, 0, 0);
      checks++;
      if (snap() !== e) begin
        errors++;
        $display("FAIL capture cyc %0d: got %h expected %h", cyc, snap(), e);
      end
    end
    wren = 1'b0;
  endtask

  // Entered in the start cycle of stage k; returns the done after 'delay' cycles (1 = start cycle).
  task automatic step_stage(input int k, input int delay, input int pk, input bit stray,
                            output bit failed);
    bit accepted;
    bit is_err;
    int idx;
    logic [4:0]  st;
    logic [38:0] e;
    accepted = 1'b0;
    is_err   = 1'b0;
    peak_idx = CntW'(pk);
    for (int c = 1; c <= TimeoutCyc; c++) begin
      done_vec = '0;
      if (c == delay) done_vec = done_vec | 5'(1 << k);
      if (stray && $urandom_range(0, 7) == 0) begin
        idx = (k + 1 + int'($urandom_range(0, 3))) % 5;
        done_vec = done_vec | 5'(1 << idx);
      end
      wren = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      done_vec = '0;
      wren     = 1'b0;
      if (c == delay && c >= 2) begin
        accepted = 1'b1;
        break;
      end
      if (c == TimeoutCyc) break;
      e = mk(0, CapLen, grant_of(k), 5'b0, m_frame, 0, 1, 0, 0);
      checks++;
      if (snap() !== e) begin
        errors++;
        $display("FAIL stage%0d_run cyc %0d: got %h expected %h", k, c, snap(), e);
      end
    end
    if (accepted && k == 3) m_frame = pk;
    if (accepted && k == 3 && pk > PeakMax) begin
      e = mk(0, CapLen, 0, 5'b0, m_frame, 0, 0, 1, 6);
      is_err = 1'b1;
    end else if (accepted && k == 4) begin
      e = mk(0, CapLen, 0, 5'b0, m_frame, 1, 0, 0, 0);
    end else if (accepted) begin
      st = 5'(1 << (k + 1));
      e  = mk(0, CapLen, grant_of(k + 1), st, m_frame, 0, 1, 0, 0);
    end else begin
      e = mk(0, CapLen, 0, 5'b0, m_frame, 0, 0, 1, k + 1);
      is_err = 1'b1;
    end
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL stage%0d_exit delay %0d pk %0d: got %h expected %h", k, delay, pk, snap(), e);
    end
    if (is_err || k == 4) begin
      for (int i = 0; i < 6; i++) begin
        done_vec = 5'($urandom);
        wren     = 1'($urandom);
        tick();
        done_vec = '0;
        wren     = 1'b0;
        checks++;
        if (snap() !== e) begin
          errors++;
          $display("FAIL stage%0d_hold cyc %0d: got %h expected %h", k, i, snap(), e);
        end
      end
    end
    failed = is_err;
  endtask

  task automatic run_burst(input int fixed_delay, input int pk, input bit stray);
    bit f;
    int d;
    capture(CapLen);
    for (int k = 0; k < 5; k++) begin
      d = (fixed_delay > 0) ? fixed_delay : rand_delay();
      step_stage(k, d, pk, stray, f);
      if (f) break;
    end
  endtask

  task automatic do_tx_done(input bit with_cprem);
    logic [38:0] e;
    done_vec = 5'($urandom);
    if (with_cprem) done_vec = done_vec | 5'b10000;
    wren    = 1'b1;
    tx_done = 1'b1;
    tick();
    tx_done  = 1'b0;
    wren     = 1'b0;
    done_vec = '0;
    m_frame  = 0;
    e = mk(1, 0, 1, 5'b0, 0, 0, 0, 0, 0);
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL tx_done: got %h expected %h", snap(), e);
    end
  endtask

  task automatic test_reset();
    logic [38:0] e;
    rst_n = 1'b0;
    repeat (3) tick();
    e = mk(1, 0, 1, 5'b0, 0, 0, 0, 0, 0);
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL reset: got %h expected %h", snap(), e);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", snap(), e);
    end
  endtask

  task automatic test_nominal();
    run_burst(10, 37, 1'b0);
    do_tx_done(1'b0);
  endtask

  task automatic test_stray();
    bit f;
    logic [38:0] e;
    capture(CapLen);
    done_vec = 5'b00011;
    tick();
    done_vec = '0;
    e = mk(0, CapLen, 2, 5'b0, 0, 0, 1, 0, 0);
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL stray_start_cycle: got %h expected %h", snap(), e);
    end
    done_vec = 5'b11110;
    tick();
    done_vec = '0;
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL stray_other_done: got %h expected %h", snap(), e);
    end
    tick();
    done_vec = 5'b00001;
    tick();
    done_vec = '0;
    e = mk(0, CapLen, 3, 5'b00010, 0, 0, 1, 0, 0);
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL stray_late_corr: got %h expected %h", snap(), e);
    end
    for (int k = 1; k < 5; k++) step_stage(k, int'($urandom_range(2, 20)), 500, 1'b1, f);
    do_tx_done(1'b0);
  endtask

  task automatic test_timeout();
    bit f;
    capture(CapLen);
    step_stage(0, 5, 37, 1'b0, f);
    step_stage(1, TimeoutCyc, 37, 1'b0, f);
    step_stage(2, TimeoutCyc + 50, 37, 1'b0, f);
    do_tx_done(1'b0);
  endtask

  task automatic test_range();
    run_burst(8, PeakMax + 1, 1'b0);
    do_tx_done(1'b0);
    run_burst(8, PeakMax, 1'b0);
    do_tx_done(1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      run_burst(0, int'($urandom_range(0, 1200)), 1'b1);
      do_tx_done(1'b0);
    end
  endtask

  task automatic test_abort();
    bit f;
    logic [38:0] e;
    capture(500);
    do_tx_done(1'b0);
    capture(CapLen);
    for (int k = 0; k < 4; k++) step_stage(k, 6, 200, 1'b0, f);
    repeat (3) tick();
    do_tx_done(1'b1);
    repeat (5) tick();
    e = mk(1, 0, 1, 5'b0, 0, 0, 0, 0, 0);
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL abort_stays_capture: got %h expected %h", snap(), e);
    end
  endtask

  task automatic test_reset_vs_tx();
    logic [38:0] e;
    run_burst(4, 100, 1'b0);
    rst_n   = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    m_frame = 0;
    e = mk(1, 0, 1, 5'b0, 0, 0, 0, 0, 0);
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL reset_vs_tx: got %h expected %h", snap(), e);
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stray();
    test_timeout();
    test_range();
    test_random();
    test_abort();
    test_reset_vs_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timesync_sequencer.md
Name: timesync_sequencer

Overview:
Top-level phase controller for the BRAM-based OFDM time-synchronizer datapath. It steps through input capture, correlation (P), energy (R), metric (M), peak search and cyclic-prefix removal. It issues a one-cycle start pulse to each engine and waits for that engine's done pulse. It also owns the shared input-buffer port select, so only one engine drives the buffer BRAM at a time, and it flags stage timeouts.

Parameters:
CAP_LEN, 2240, samples captured per burst window (2 x OFDM burst size 1120)
FRAME_SPAN, 1120, samples needed after the detected frame start; legal peak_idx range is 0..CAP_LEN-FRAME_SPAN
TIMEOUT_CYC, 262143, max cycles a compute stage may run before error
CNT_W, 12, width of cap_count / peak_idx / frame_idx
TO_W, 18, width of the timeout counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
tx_done  in  1  burst consumed; restart the capture cycle
wren  in  1  input sample valid
wr_accept  out  1  capture writer may write the buffer this cycle
cap_count  out  CNT_W  samples captured so far
corr_start / energy_start / metric_start / peak_start / cprem_start  out  1 each  one-cycle engine start pulses
corr_done / energy_done / metric_done / peak_done / cprem_done  in  1 each  one-cycle engine done pulses
peak_idx  in  CNT_W  frame start index from the peak engine, valid with peak_done
frame_idx  out  CNT_W  latched frame start index
buf_grant  out  3  input-buffer port owner: 0 none, 1 capture, 2 corr, 3 energy, 4 cprem
out_buff_full  out  1  output buffer valid for readout
busy  out  1  high in any compute state
err  out  1  sticky error flag
err_code  out  3  0 none, 1-5 timeout in corr/energy/metric/peak/cprem, 6 peak_idx out of range

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at an edge): state=CAPTURE, cap_count=0, wr_accept=1, buf_grant=1, all start pulses 0, frame_idx=0, out_buff_full=0, busy=0, err=0, err_code=0. Reset has priority over tx_done.
- States and port ownership:
  - CAPTURE: owner 1
  - CORR: owner 2
  - ENERGY: owner 3
  - METRIC: owner 0
  - PEAK: owner 0
  - CPREM: owner 4
  - READY: owner 0
  - ERROR: owner 0
- buf_grant changes on the same edge as the state register.
- CAPTURE:
  - Each wren=1 cycle increments cap_count.
  - The edge where cap_count goes CAP_LEN-1 -> CAP_LEN moves the state to CORR.
  - wr_accept=0 from that cycle onward.
  - wren is ignored in every state other than CAPTURE, and cap_count holds.
- Compute states (CORR, ENERGY, METRIC, PEAK, CPREM):
  - The state's start pulse is high for exactly the first cycle in the state. busy=1.
  - The matching done pulse is honoured only from the cycle after the start pulse. A done in the start cycle is ignored.
  - Done pulses belonging to other stages are ignored.
  - Done sampled at edge N: next state entered at N, and its start pulse is high in cycle N+1.
  - Order: CORR -> ENERGY -> METRIC -> PEAK -> CPREM -> READY.
- PEAK:
  - On peak_done, frame_idx <= peak_idx.
  - If peak_idx > CAP_LEN-FRAME_SPAN: go to ERROR with err_code=6 instead of CPREM. frame_idx is still latched.
- Timeout:
  - A TO_W counter clears on entry to each compute state.
  - When the counter reaches TIMEOUT_CYC-1 with no done pulse: go to ERROR, err=1, err_code=stage code.
  - A done pulse arriving on the same cycle as the timeout wins.
- READY:
  - out_buff_full=1, busy=0, buf_grant=0.
  - Holds until tx_done.
- ERROR:
  - err and err_code hold, busy=0, no start pulses.
  - Exits only on tx_done or reset.
- tx_done=1 at any edge, any state, including mid-stage:
  - Next state is CAPTURE, cap_count=0, wr_accept=1, buf_grant=1.
  - out_buff_full=0, err=0, err_code=0, frame_idx=0.
  - No start pulse is issued.
  - A simultaneous done or wren is discarded.
- Exactly one start pulse may be high in any cycle. buf_grant never selects two owners.

Test Plan:
- Nominal run: reset, then 2240 wren pulses -> wr_accept falls after sample 2240, buf_grant=2, corr_start high 1 cycle. Return each done 10 cycles after its start, with peak_idx=37 -> start pulses in order, frame_idx=37, out_buff_full=1, buf_grant=0, err=0.
- Early/stray done: energy_done pulsed during CORR, and corr_done in the same cycle as corr_start -> both ignored, state stays CORR. A later corr_done advances to ENERGY.
- Timeout: TIMEOUT_CYC=100, metric_done never returned -> 100 cycles after METRIC entry: err=1, err_code=3, no further start pulses. tx_done -> err=0, state CAPTURE.
- Range check: peak_idx=1121 -> err_code=6, no cprem_start, frame_idx=1121. peak_idx=1120 -> accepted.
- Abort mid-capture and mid-CPREM: tx_done at cap_count=500 and during CPREM -> cap_count=0, buf_grant=1, out_buff_full=0. A cprem_done asserted with tx_done has no effect.
- Reset vs tx_done: rst_n=0 and tx_done=1 in the same cycle, in READY -> all reset values, out_buff_full=0.
